// File: rtl/sram_mem_ctrl.sv
// SRAM memory controller: splits each 32-bit CPU load/store into two 16-bit
// SRAM half accesses (low half, then high half), each lasting WAIT_CYCLES
// clocks, and reports completion on ready so the pipeline can freeze.
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_en,
    input  logic               MEM_W_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned IDX_W = SRAM_AW - 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_wr;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wdata;

    logic [31:0]      offset;
    logic [IDX_W-1:0] req_idx;

    // Word index of the incoming request; addresses below BASE_ADDR wrap.
    assign offset  = address - BASE_ADDR;
    assign req_idx = IDX_W'(offset >> 2);

    // Completion / idle handshake toward the pipeline freeze logic.
    assign ready = (state == DONE) ||
                   ((state == IDLE) && !MEM_R_en && !MEM_W_en);

    // Access sequencer; SRAM strobes are registered for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_R_en || MEM_W_en) begin
                        state       <= LO;
                        cnt         <= '0;
                        op_wr       <= MEM_W_en;
                        idx         <= req_idx;
                        wdata       <= write_data;
                        sram_addr   <= {req_idx, 1'b0};
                        sram_we_n   <= ~MEM_W_en;
                        sram_dq_oe  <= MEM_W_en;
                        sram_dq_out <= MEM_W_en ? write_data[15:0] : 16'h0000;
                    end
                end
                LO: begin
                    if (cnt == CNT_LAST) begin
                        state     <= HI;
                        cnt       <= '0;
                        sram_addr <= {idx, 1'b1};
                        if (op_wr) begin
                            sram_dq_out <= wdata[31:16];
                        end else begin
                            read_data[15:0] <= sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HI: begin
                    if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        cnt         <= '0;
                        sram_addr   <= '0;
                        sram_dq_out <= 16'h0000;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                        if (!op_wr) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl at WAIT_CYCLES=2, BASE_ADDR=1024, SRAM_AW=18.
module tb_sram_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        MEM_R_en;
    logic        MEM_W_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int n_checks;
    int n_fail;

    sram_mem_ctrl #(
        .WAIT_CYCLES(2),
        .BASE_ADDR  (32'd1024),
        .SRAM_AW    (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_en   (MEM_R_en),
        .MEM_W_en   (MEM_W_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents: 0xBEEF at 0, 0xDEAD at 1, address-derived pattern elsewhere.
    assign sram_dq_in = (sram_addr == 18'd0) ? 16'hBEEF :
                        (sram_addr == 18'd1) ? 16'hDEAD :
                        (sram_addr[15:0] ^ 16'hA5A5);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        n_checks++; if (read_data !== 32'h0)   begin n_fail++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
        n_checks++; if (sram_we_n !== 1'b1)    begin n_fail++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
        n_checks++; if (sram_dq_oe !== 1'b0)   begin n_fail++; $display("FAIL reset_oe got=%b exp=0", sram_dq_oe); end
        n_checks++; if (sram_addr !== 18'h0)   begin n_fail++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
        n_checks++; if (sram_dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_dq_out got=%h exp=0", sram_dq_out); end
        n_checks++; if (ready !== 1'b1)        begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_idle;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++; if (ready !== 1'b1)      begin n_fail++; $display("FAIL idle_ready c=%0d got=%b exp=1", c, ready); end
            n_checks++; if (sram_we_n !== 1'b1)  begin n_fail++; $display("FAIL idle_we_n c=%0d got=%b exp=1", c, sram_we_n); end
            n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL idle_oe c=%0d got=%b exp=0", c, sram_dq_oe); end
        end
    endtask

    task automatic test_read;
        logic [17:0] e_addr;
        MEM_R_en = 1'b1;
        address  = 32'd1024;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL read_req_ready got=%b exp=0", ready); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) MEM_R_en = 1'b0;
            e_addr = (c <= 2) ? 18'd0 : (c <= 4) ? 18'd1 : 18'd0;
            n_checks++; if (ready !== (c == 5))  begin n_fail++; $display("FAIL read_ready c=%0d got=%b exp=%b", c, ready, (c == 5)); end
            n_checks++; if (sram_addr !== e_addr) begin n_fail++; $display("FAIL read_addr c=%0d got=%h exp=%h", c, sram_addr, e_addr); end
            n_checks++; if (sram_we_n !== 1'b1)  begin n_fail++; $display("FAIL read_we_n c=%0d got=%b exp=1", c, sram_we_n); end
            n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe c=%0d got=%b exp=0", c, sram_dq_oe); end
            if (c == 3) begin
                n_checks++; if (read_data[15:0] !== 16'hBEEF) begin n_fail++; $display("FAIL read_low_half got=%h exp=beef", read_data[15:0]); end
            end
        end
        n_checks++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got=%h exp=deadbeef", read_data); end
        tick();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL read_after_ready got=%b exp=1", ready); end
    endtask

    task automatic test_write;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        MEM_W_en   = 1'b1;
        address    = 32'd1032;
        write_data = 32'h12345678;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) MEM_W_en = 1'b0;
            e_addr = (c <= 2) ? 18'd4 : (c <= 4) ? 18'd5 : 18'd0;
            e_dq   = (c <= 2) ? 16'h5678 : (c <= 4) ? 16'h1234 : 16'h0000;
            n_checks++; if (ready !== (c == 5))       begin n_fail++; $display("FAIL write_ready c=%0d got=%b exp=%b", c, ready, (c == 5)); end
            n_checks++; if (sram_addr !== e_addr)     begin n_fail++; $display("FAIL write_addr c=%0d got=%h exp=%h", c, sram_addr, e_addr); end
            n_checks++; if (sram_we_n !== (c == 5))   begin n_fail++; $display("FAIL write_we_n c=%0d got=%b exp=%b", c, sram_we_n, (c == 5)); end
            n_checks++; if (sram_dq_oe !== (c != 5))  begin n_fail++; $display("FAIL write_oe c=%0d got=%b exp=%b", c, sram_dq_oe, (c != 5)); end
            n_checks++; if (sram_dq_out !== e_dq)     begin n_fail++; $display("FAIL write_dq_out c=%0d got=%h exp=%h", c, sram_dq_out, e_dq); end
        end
        n_checks++; if (read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_keeps_read_data got=%h exp=deadbeef", read_data); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [17:0] e_addr;
        // Read at 1028 (half addresses 2,3), request held through DONE.
        MEM_R_en = 1'b1;
        address  = 32'd1028;
        for (int c = 1; c <= 5; c++) begin
            tick();
            e_addr = (c <= 2) ? 18'd2 : (c <= 4) ? 18'd3 : 18'd0;
            n_checks++; if (ready !== (c == 5))   begin n_fail++; $display("FAIL b2b_rd_ready c=%0d got=%b exp=%b", c, ready, (c == 5)); end
            n_checks++; if (sram_addr !== e_addr) begin n_fail++; $display("FAIL b2b_rd_addr c=%0d got=%h exp=%h", c, sram_addr, e_addr); end
        end
        n_checks++; if (read_data !== 32'hA5A6A5A7) begin n_fail++; $display("FAIL b2b_rd_data got=%h exp=a5a6a5a7", read_data); end
        // Cycle after DONE: back in IDLE, no restart of the held read.
        tick();
        n_checks++; if (sram_we_n !== 1'b1)   begin n_fail++; $display("FAIL b2b_idle_we_n got=%b exp=1", sram_we_n); end
        n_checks++; if (sram_addr !== 18'd0)  begin n_fail++; $display("FAIL b2b_idle_addr got=%h exp=0", sram_addr); end
        n_checks++; if (ready !== 1'b0)       begin n_fail++; $display("FAIL b2b_idle_ready got=%b exp=0", ready); end
        MEM_R_en   = 1'b0;
        MEM_W_en   = 1'b1;
        address    = 32'd1036;
        write_data = 32'hCAFEF00D;
        for (int c = 1; c <= 5; c++) begin
            tick();
            e_addr = (c <= 2) ? 18'd6 : (c <= 4) ? 18'd7 : 18'd0;
            n_checks++; if (ready !== (c == 5))     begin n_fail++; $display("FAIL b2b_wr_ready c=%0d got=%b exp=%b", c, ready, (c == 5)); end
            n_checks++; if (sram_addr !== e_addr)   begin n_fail++; $display("FAIL b2b_wr_addr c=%0d got=%h exp=%h", c, sram_addr, e_addr); end
            n_checks++; if (sram_we_n !== (c == 5)) begin n_fail++; $display("FAIL b2b_wr_we_n c=%0d got=%b exp=%b", c, sram_we_n, (c == 5)); end
        end
        MEM_W_en = 1'b0;
        tick();
        n_checks++; if (ready !== 1'b1)     begin n_fail++; $display("FAIL b2b_end_ready got=%b exp=1", ready); end
        n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL b2b_end_we_n got=%b exp=1", sram_we_n); end
        n_checks++; if (read_data !== 32'hA5A6A5A7) begin n_fail++; $display("FAIL b2b_end_read_data got=%h exp=a5a6a5a7", read_data); end
    endtask

    task automatic test_both_wrap;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        MEM_R_en   = 1'b1;
        MEM_W_en   = 1'b1;
        address    = 32'd1020;
        write_data = 32'h0A0B0C0D;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                MEM_R_en = 1'b0;
                MEM_W_en = 1'b0;
            end
            e_addr = (c <= 2) ? 18'h3FFFE : (c <= 4) ? 18'h3FFFF : 18'd0;
            e_dq   = (c <= 2) ? 16'h0C0D : (c <= 4) ? 16'h0A0B : 16'h0000;
            n_checks++; if (sram_addr !== e_addr)   begin n_fail++; $display("FAIL both_addr c=%0d got=%h exp=%h", c, sram_addr, e_addr); end
            n_checks++; if (sram_we_n !== (c == 5)) begin n_fail++; $display("FAIL both_we_n c=%0d got=%b exp=%b", c, sram_we_n, (c == 5)); end
            n_checks++; if (sram_dq_out !== e_dq)   begin n_fail++; $display("FAIL both_dq_out c=%0d got=%h exp=%h", c, sram_dq_out, e_dq); end
        end
        n_checks++; if (read_data !== 32'hA5A6A5A7) begin n_fail++; $display("FAIL both_read_data got=%h exp=a5a6a5a7", read_data); end
        tick();
    endtask

    task automatic test_reset_mid;
        MEM_W_en   = 1'b1;
        address    = 32'd1032;
        write_data = 32'h11112222;
        repeat (3) tick();
        MEM_W_en = 1'b0;
        n_checks++; if (sram_we_n !== 1'b0)   begin n_fail++; $display("FAIL rstmid_pre_we_n got=%b exp=0", sram_we_n); end
        n_checks++; if (sram_addr !== 18'd5)  begin n_fail++; $display("FAIL rstmid_pre_addr got=%h exp=5", sram_addr); end
        rst = 1'b0;
        #1;
        n_checks++; if (sram_we_n !== 1'b1)    begin n_fail++; $display("FAIL rstmid_we_n got=%b exp=1", sram_we_n); end
        n_checks++; if (sram_dq_oe !== 1'b0)   begin n_fail++; $display("FAIL rstmid_oe got=%b exp=0", sram_dq_oe); end
        n_checks++; if (sram_addr !== 18'd0)   begin n_fail++; $display("FAIL rstmid_addr got=%h exp=0", sram_addr); end
        n_checks++; if (sram_dq_out !== 16'h0) begin n_fail++; $display("FAIL rstmid_dq_out got=%h exp=0", sram_dq_out); end
        n_checks++; if (read_data !== 32'h0)   begin n_fail++; $display("FAIL rstmid_read_data got=%h exp=0", read_data); end
        n_checks++; if (ready !== 1'b1)        begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        repeat (2) tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (ready !== 1'b1)     begin n_fail++; $display("FAIL rstpost_ready c=%0d got=%b exp=1", c, ready); end
            n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rstpost_we_n c=%0d got=%b exp=1", c, sram_we_n); end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        MEM_R_en   = 1'b0;
        MEM_W_en   = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        test_reset();
        test_idle();
        test_read();
        test_write();
        test_back_to_back();
        test_both_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: SRAM clock cycles per 16-bit half access; legal range 1..15.
REQ-002 SHALL have parameter BASE_ADDR, default 1024: CPU byte address that maps to SRAM word 0.
REQ-003 SHALL have parameter SRAM_AW, default 18: SRAM address width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port MEM_R_en, input, 1 bit: read request from the EXE/MEM stage.
REQ-007 SHALL have port MEM_W_en, input, 1 bit: write request from the EXE/MEM stage.
REQ-008 SHALL have port address, input, 32 bits: CPU byte address.
REQ-009 SHALL have port write_data, input, 32 bits: store data.
REQ-010 SHALL have port read_data, output, 32 bits: registered load result, fed to the Mem_read_value input of the MEM pipeline register.
REQ-011 SHALL have port ready, output, 1 bit: access complete; the pipeline drives freeze = ~ready.
REQ-012 SHALL have port sram_addr, output, SRAM_AW bits: SRAM half-word address.
REQ-013 SHALL have port sram_dq_out, output, 16 bits: write data toward the SRAM.
REQ-014 SHALL have port sram_dq_in, input, 16 bits: read data from the SRAM.
REQ-015 SHALL have port sram_dq_oe, output, 1 bit: data-bus drive enable (1 = controller drives).
REQ-016 SHALL have port sram_we_n, output, 1 bit: active-low SRAM write strobe.

Function
REQ-017 SHALL implement a state machine with states IDLE, LO, HI, DONE, plus a 4-bit wait counter.
REQ-018 In IDLE, a sampled MEM_R_en or MEM_W_en SHALL move the FSM to LO at the next edge and latch op (write if MEM_W_en), word index and write_data.
REQ-019 SHALL give MEM_W_en priority when MEM_R_en and MEM_W_en are asserted together; the operation is performed as a write.
REQ-020 SHALL compute word index = (address - BASE_ADDR) >> 2 modulo 2^32, truncated to SRAM_AW-1 bits; addresses below BASE_ADDR wrap without error.
REQ-021 sram_addr SHALL be {index, 1'b0} in LO and {index, 1'b1} in HI.
REQ-022 LO and HI SHALL each last exactly WAIT_CYCLES cycles; the counter clears on each phase entry.
REQ-023 DONE SHALL last exactly 1 cycle, then return unconditionally to IDLE.
REQ-024 ready SHALL be combinational: 1 in DONE; 1 in IDLE when neither request is asserted; 0 otherwise.
REQ-025 Latency: a request first seen in IDLE at cycle 0 SHALL produce ready=1 at cycle 2*WAIT_CYCLES+1.
REQ-026 A request still asserted during DONE SHALL NOT be restarted; a new or held request is sampled only in IDLE, following DONE.
REQ-027 Reads: read_data[15:0] SHALL capture sram_dq_in on the final LO cycle and read_data[31:16] on the final HI cycle.
REQ-028 read_data SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-029 Writes: in LO and HI, sram_we_n=0 and sram_dq_oe=1, with sram_dq_out = write_data[15:0] in LO and write_data[31:16] in HI.
REQ-030 sram_we_n=1 and sram_dq_oe=0 SHALL hold in IDLE, in DONE, and throughout every read.
REQ-031 sram_dq_out SHALL be 0 whenever sram_dq_oe=0.
REQ-032 Requests arriving mid-access SHALL NOT alter the latched address, data or op.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, counter 0, read_data 0, latched op/index/data 0, sram_we_n=1, sram_dq_oe=0, sram_addr 0 and sram_dq_out 0.
REQ-034 Reset asserted mid-access SHALL abort the access with no further SRAM strobes; after release, ready reflects the inputs per REQ-024.

Verification
REQ-035 Read at address=1024, WAIT_CYCLES=2, SRAM returns 0xBEEF (addr 0) and 0xDEAD (addr 1) -> sram_addr 0,0,1,1; ready high at cycle 5; read_data=0xDEADBEEF.
REQ-036 Write at address=1032 with data 0x12345678 -> sram_addr 4 then 5, each with sram_we_n=0; sram_dq_out 0x5678 then 0x1234; read_data unchanged.
REQ-037 Back-to-back read then write held across DONE -> exactly one access per request; second access begins one cycle after DONE.
REQ-038 MEM_R_en=MEM_W_en=1 at address=1020 -> write performed at wrapped index (all-ones truncated); read_data unchanged.
REQ-039 rst pulsed low during HI of a write -> sram_we_n=1 within the reset cycle; state IDLE; read_data=0.
REQ-040 No request for 10 cycles -> ready=1 constantly, sram_we_n=1, sram_dq_oe=0.
